// File: rtl/gate_check_pkg.sv
// Shared types and truth-table constants for the 2-input gate truth-table checker.
package gate_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // Truth tables are indexed by {a,b}.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_truth_checker_settle_timer.sv
// Loadable down-counter that counts the settle interval after each new vector is driven.
module settle_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// Truth-table sequencer: drives a/b through 00,01,10,11, samples y after a settle interval,
// and accumulates per-vector mismatches into a pass/fail result.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for start; results of last run held
// ST_DRIVE  | present vec on a/b, load settle timer
// ST_SETTLE | wait for settle timer to reach zero
// ST_SAMPLE | compare y with expected bit, advance vec
// ST_DONE   | one-cycle done pulse, return a/b to 00
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter logic [3:0] EXP_TABLE     = TT_NOR,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] err_mask
);

  localparam int TW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [1:0] vec;
  logic       timer_load;
  logic       timer_zero;
  logic       mismatch;
  logic [2:0] err_count_nxt;

  settle_timer #(.WIDTH(TW)) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .zero     (timer_zero)
  );

  // Case inequality so an X/Z on y counts as a mismatch in simulation.
  assign mismatch      = (y !== EXP_TABLE[vec]);
  assign err_count_nxt = err_count + 3'(mismatch);
  assign done          = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    timer_load = 1'b0;
    unique case (state)
      ST_IDLE:   if (start) state_nxt = ST_DRIVE;
      ST_DRIVE: begin
        timer_load = 1'b1;
        state_nxt  = ST_SETTLE;
      end
      ST_SETTLE: if (timer_zero) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = (vec == 2'd3) ? ST_DONE : ST_DRIVE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      err_mask  <= '0;
      vec       <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            err_count <= '0;
            err_mask  <= '0;
            pass      <= 1'b0;
            vec       <= '0;
          end
        end
        ST_DRIVE: begin
          {a, b} <= vec;
          busy   <= 1'b1;
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            err_mask[vec] <= 1'b1;
            err_count     <= err_count_nxt;
          end
          // Result is committed on the way into DONE so it is valid while done pulses.
          if (vec == 2'd3) begin
            pass <= (err_count_nxt == 3'd0);
            busy <= 1'b0;
          end else begin
            vec <= vec + 2'd1;
          end
        end
        ST_DONE: begin
          {a, b} <= 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench: three checkers (settle 2, 1, 15) around behavioural gates; stimulus pushes
// expected results, a negedge monitor checks timing, vector order and results as runs complete.
module tb_gate_truth_checker;
  import gate_check_pkg::*;

  localparam int M_NOR  = 0;
  localparam int M_NAND = 1;
  localparam int M_TIE0 = 2;
  localparam int M_TIE1 = 3;

  typedef struct {
    int idx;
    int acc;
    int cnt;
    int mask;
    int pass;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start_v [3];
  logic       a_v     [3];
  logic       b_v     [3];
  logic       y_v     [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic       pass_v  [3];
  logic [2:0] cnt_v   [3];
  logic [3:0] mask_v  [3];
  int         mode_v  [3];
  int         settle_v[3];

  exp_t q[$];
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_err   = 0;

  function automatic logic gate_fn(int mode, logic ga, logic gb);
    case (mode)
      M_NOR:   return ~(ga | gb);
      M_NAND:  return ~(ga & gb);
      M_TIE0:  return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  assign y_v[0] = gate_fn(mode_v[0], a_v[0], b_v[0]);
  assign y_v[1] = gate_fn(mode_v[1], a_v[1], b_v[1]);
  assign y_v[2] = gate_fn(mode_v[2], a_v[2], b_v[2]);

  gate_truth_checker #(.EXP_TABLE(TT_NOR), .SETTLE_CYCLES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]), .y(y_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(cnt_v[0]), .err_mask(mask_v[0])
  );
  gate_truth_checker #(.EXP_TABLE(TT_NOR), .SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]), .y(y_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(cnt_v[1]), .err_mask(mask_v[1])
  );
  gate_truth_checker #(.EXP_TABLE(TT_NOR), .SETTLE_CYCLES(15)) u_dut15 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]), .y(y_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(cnt_v[2]), .err_mask(mask_v[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int outs_word(int i);
    return int'({a_v[i], b_v[i], busy_v[i], done_v[i], pass_v[i], cnt_v[i], mask_v[i]});
  endfunction

  // Monitor: d counts edges since the accept edge; done is due after 4*(S+2) edges.
  always @(negedge clk) begin
    int d, s, i, exp_idx;
    if (rst_n) begin
      exp_idx = (q.size() > 0) ? q[0].idx : -1;
      for (int j = 0; j < 3; j++) begin
        if (done_v[j] && j != exp_idx) check($sformatf("unexpected_done%0d", j), 1, 0);
      end
      if (q.size() > 0) begin
        i = q[0].idx;
        d = cyc - q[0].acc;
        s = settle_v[i];
        if (d == 1) begin
          check("busy_after_accept", int'(busy_v[i]), 1);
          check("cleared_on_accept", int'({pass_v[i], cnt_v[i], mask_v[i]}), 0);
        end
        for (int k = 0; k < 4; k++) begin
          if (d == 1 + k * (s + 2)) check($sformatf("vec%0d_ab", k), int'({a_v[i], b_v[i]}), k);
        end
        if (done_v[i]) begin
          check("done_latency", d, 4 * (s + 2));
          check("busy_at_done", int'(busy_v[i]), 0);
          check("err_count", int'(cnt_v[i]), q[0].cnt);
          check("err_mask", int'(mask_v[i]), q[0].mask);
          check("pass", int'(pass_v[i]), q[0].pass);
          void'(q.pop_front());
        end else if (d > 4 * (s + 2) + 4) begin
          check("done_timeout", d, 4 * (s + 2));
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic push_exp(int idx, int acc, int cnt, int mask, int pass);
    exp_t e;
    e.idx = idx; e.acc = acc; e.cnt = cnt; e.mask = mask; e.pass = pass;
    q.push_back(e);
  endtask

  task automatic start_run(int idx, int mode, int cnt, int mask, int pass);
    @(negedge clk);
    mode_v[idx]  = mode;
    start_v[idx] = 1'b1;
    @(posedge clk); #1;
    push_exp(idx, cyc, cnt, mask, pass);
    start_v[idx] = 1'b0;
  endtask

  task automatic wait_empty(int max_cycles);
    for (int n = 0; n < max_cycles; n++) begin
      @(negedge clk); #1;
      if (q.size() == 0) return;
    end
    check("drain_timeout", q.size(), 0);
    q.delete();
  endtask

  initial begin
    int acc;
    settle_v[0] = 2; settle_v[1] = 1; settle_v[2] = 15;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      mode_v[i]  = M_NOR;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("reset_outputs%0d", i), outs_word(i), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // NOR gate, matching table.
    start_run(0, M_NOR, 0, 4'b0000, 1);
    wait_empty(40);
    // NAND gate against NOR table: 01 and 10 mismatch.
    start_run(0, M_NAND, 2, 4'b0110, 0);
    wait_empty(40);
    // y tied 0 then, back-to-back, y tied 1 (start raised in the DONE cycle is ignored).
    start_run(0, M_TIE0, 1, 4'b0001, 0);
    wait_empty(40);
    mode_v[0]  = M_TIE1;
    start_v[0] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    push_exp(0, cyc, 3, 4'b1110, 0);
    start_v[0] = 1'b0;
    wait_empty(40);

    // start held high: one run per IDLE visit, re-accepted after DONE.
    @(negedge clk);
    mode_v[0]  = M_NOR;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    push_exp(0, acc, 0, 4'b0000, 1);
    push_exp(0, acc + 18, 0, 4'b0000, 1);
    for (int n = 0; n < 40 && cyc < acc + 18; n++) begin
      @(posedge clk); #1;
    end
    start_v[0] = 1'b0;
    wait_empty(60);

    // Reset during SETTLE of vector 2.
    start_run(0, M_NOR, 0, 4'b0000, 1);
    acc = q[0].acc;
    for (int n = 0; n < 20 && cyc < acc + 10; n++) begin
      @(posedge clk); #1;
    end
    check("pre_reset_ab", int'({a_v[0], b_v[0]}), 2);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", outs_word(0), 0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("post_reset_idle", outs_word(0), 0);
    start_run(0, M_NOR, 0, 4'b0000, 1);
    wait_empty(40);

    // Shortest and longest settle intervals.
    start_run(1, M_NOR, 0, 4'b0000, 1);
    wait_empty(40);
    start_run(2, M_NOR, 0, 4'b0000, 1);
    wait_empty(100);
    start_run(1, M_NAND, 2, 4'b0110, 0);
    wait_empty(40);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
